ring_osc_meter: RTL and testbench

- Controller/measurement sequencer for the on-chip ring oscillator.
- Gates the oscillator enable, waits a settling interval, then counts rising edges of the oscillator's divided output over a programmable window of system clock cycles.
- Reports the count with a start/busy/done handshake.
- Sits between the game/debug logic (clk domain) and the free-running oscillator, which is asynchronous to clk.

---
 rtl/ring_osc_meter.sv | 148 ++++++++++++++
 tb/tb_ring_osc_meter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ring_osc_meter.sv
// Ring oscillator measurement sequencer: enables the oscillator, waits a fixed
// warm-up, then counts synchronized osc_in rising edges over a gate window.
module ring_osc_meter #(
  parameter int unsigned GATE_BITS     = 16,
  parameter int unsigned COUNT_BITS    = 16,
  parameter int unsigned WARMUP_CYCLES = 16,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [GATE_BITS-1:0]  gate_len,
  input  logic                  osc_in,
  output logic                  osc_en,
  output logic                  busy,
  output logic                  done,
  output logic [COUNT_BITS-1:0] result,
  output logic                  result_valid,
  output logic                  overflow
);

  localparam int unsigned WARM_BITS = $clog2(WARMUP_CYCLES + 1);
  localparam logic [WARM_BITS-1:0] WARM_LOAD = WARM_BITS'(WARMUP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARMUP,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic                   accept;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   osc_rise;
  logic [WARM_BITS-1:0]   warm_cnt;
  logic [GATE_BITS-1:0]   gate_reg;
  logic [GATE_BITS-1:0]   gate_cnt;
  logic [COUNT_BITS-1:0]  count;
  logic                   ovf_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign osc_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    osc_en  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          accept  = 1'b1;
          state_d = S_WARMUP;
        end
      end
      S_WARMUP: begin
        osc_en = 1'b1;
        busy   = 1'b1;
        if (abort)                state_d = S_IDLE;
        else if (warm_cnt == '0)  state_d = (gate_reg == '0) ? S_DONE : S_MEASURE;
      end
      S_MEASURE: begin
        osc_en = 1'b1;
        busy   = 1'b1;
        if (abort)                state_d = S_IDLE;
        else if (gate_cnt == '0)  state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = ~abort;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt     <= '0;
      gate_reg     <= '0;
      gate_cnt     <= '0;
      count        <= '0;
      ovf_flag     <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            gate_reg     <= gate_len;
            warm_cnt     <= WARM_LOAD;
            count        <= '0;
            ovf_flag     <= 1'b0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
          end
        end
        S_WARMUP: begin
          // gate_cnt is preloaded every warm-up cycle so MEASURE starts at gate_reg-1
          gate_cnt <= gate_reg - 1'b1;
          if (warm_cnt != '0) warm_cnt <= warm_cnt - 1'b1;
          if (abort) result_valid <= 1'b0;
        end
        S_MEASURE: begin
          if (abort) begin
            result_valid <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt - 1'b1;
            if (osc_rise) begin
              if (count == '1) ovf_flag <= 1'b1;
              else             count    <= count + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (abort) begin
            result_valid <= 1'b0;
          end else begin
            result       <= count;
            overflow     <= ovf_flag;
            result_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_osc_meter.sv
// Directed bench for ring_osc_meter: table of measurement windows plus abort,
// handshake and asynchronous-reset sequences, on a 16-bit and a 4-bit counter.
module tb_ring_osc_meter;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] gate_len = '0;
  logic        osc_in = 1'b0;

  logic        osc_en, busy, done, result_valid, overflow;
  logic [15:0] result;
  logic        osc_en4, busy4, done4, result_valid4, overflow4;
  logic [3:0]  result4;

  int checks = 0;
  int failures = 0;
  int half = 0;
  int ph = 0;

  ring_osc_meter #(.GATE_BITS(16), .COUNT_BITS(16), .WARMUP_CYCLES(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_len(gate_len),
    .osc_in(osc_in), .osc_en(osc_en), .busy(busy), .done(done), .result(result),
    .result_valid(result_valid), .overflow(overflow)
  );

  ring_osc_meter #(.GATE_BITS(16), .COUNT_BITS(4), .WARMUP_CYCLES(W), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_len(gate_len),
    .osc_in(osc_in), .osc_en(osc_en4), .busy(busy4), .done(done4), .result(result4),
    .result_valid(result_valid4), .overflow(overflow4)
  );

  always #5 clk = ~clk;

  // Oscillator model: toggles every 'half' clk cycles; half==0 holds it low.
  always @(negedge clk) begin
    if (half == 0) begin
      osc_in <= 1'b0;
      ph     <= 0;
    end else if (ph >= half - 1) begin
      osc_in <= ~osc_in;
      ph     <= 0;
    end else begin
      ph <= ph + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_meas(input string tag, input int g, input int h,
                          input int er, input int eo, input int er4, input int eo4);
    int busy_c, en_c, done_c, done_at;
    bit finished;
    half = h;
    repeat (24) @(negedge clk);
    gate_len = 16'(g);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_c = 0; en_c = 0; done_c = 0; done_at = 0; finished = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      if (busy)   busy_c++;
      if (osc_en) en_c++;
      if (done) begin
        done_c++;
        done_at = k;
      end
      if (done_at != 0 && !busy) begin
        finished = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_finished"}, 32'(finished), 32'd1);
    chk({tag, "_done_at"}, done_at, W + g + 1);
    chk({tag, "_done_pulses"}, done_c, 1);
    chk({tag, "_busy_cycles"}, busy_c, W + g + 1);
    chk({tag, "_osc_en_cycles"}, en_c, W + g);
    chk({tag, "_result"}, 32'(result), er);
    chk({tag, "_overflow"}, 32'(overflow), eo);
    chk({tag, "_result_valid"}, 32'(result_valid), 1);
    chk({tag, "_result4"}, 32'(result4), er4);
    chk({tag, "_overflow4"}, 32'(overflow4), eo4);
  endtask

  typedef struct {
    int g;
    int h;
    int er;
    int eo;
    int er4;
    int eo4;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int nd, d1, d2, b26, b27, r26, cnt;

    vecs[0] = '{g: 80, h: 4, er: 10, eo: 0, er4: 10, eo4: 0};
    vecs[1] = '{g: 64, h: 1, er: 32, eo: 0, er4: 15, eo4: 1};
    vecs[2] = '{g: 8,  h: 1, er: 4,  eo: 0, er4: 4,  eo4: 0};
    vecs[3] = '{g: 0,  h: 1, er: 0,  eo: 0, er4: 0,  eo4: 0};
    vecs[4] = '{g: 16, h: 2, er: 4,  eo: 0, er4: 4,  eo4: 0};
    vecs[5] = '{g: 10, h: 0, er: 0,  eo: 0, er4: 0,  eo4: 0};
    vecs[6] = '{g: 2,  h: 1, er: 1,  eo: 0, er4: 1,  eo4: 0};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_osc_en", 32'(osc_en), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_result_valid", 32'(result_valid), 0);
    chk("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_meas($sformatf("vec%0d", i), vecs[i].g, vecs[i].h,
               vecs[i].er, vecs[i].eo, vecs[i].er4, vecs[i].eo4);

    // Abort on the 5th MEASURE cycle; previous result (1) must survive.
    half = 1;
    repeat (4) @(negedge clk);
    gate_len = 16'd40;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    chk("abort_pre_busy", 32'(busy), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_osc_en", 32'(osc_en), 0);
    chk("abort_result_valid", 32'(result_valid), 0);
    chk("abort_result", 32'(result), 1);
    chk("abort_result4", 32'(result4), 1);
    cnt = 0;
    repeat (60) begin
      if (done || busy) cnt++;
      @(negedge clk);
    end
    chk("abort_no_activity", cnt, 0);

    // start and abort together in IDLE: nothing starts.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    cnt = 0;
    repeat (5) begin
      if (busy || osc_en) cnt++;
      @(negedge clk);
    end
    chk("start_abort_ignored", cnt, 0);

    // start held high: back-to-back runs, gate_len change mid-run deferred.
    half = 1;
    repeat (4) @(negedge clk);
    gate_len = 16'd8;
    start = 1'b1;
    @(negedge clk);
    gate_len = 16'd20;
    nd = 0; d1 = 0; d2 = 0; b26 = -1; b27 = -1; r26 = -1;
    for (int k = 1; k <= 300; k++) begin
      if (done) begin
        if (nd == 0) d1 = k;
        else if (nd == 1) begin
          d2 = k;
          start = 1'b0;
        end
        nd++;
      end
      if (k == 26) begin
        b26 = 32'(busy);
        r26 = 32'(result);
      end
      if (k == 27) b27 = 32'(busy);
      if (nd == 2 && !busy) break;
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b_done1_at", d1, W + 8 + 1);
    chk("b2b_idle_gap_busy", b26, 0);
    chk("b2b_result1", r26, 4);
    chk("b2b_restart_busy", b27, 1);
    chk("b2b_done2_at", d2, 26 + W + 20 + 1);
    chk("b2b_done_count", nd, 2);
    chk("b2b_result2", 32'(result), 10);
    repeat (3) @(negedge clk);
    chk("b2b_stops", 32'(busy), 0);

    // Asynchronous reset during MEASURE.
    half = 2;
    repeat (4) @(negedge clk);
    gate_len = 16'd40;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (W + 10) @(negedge clk);
    chk("mid_pre_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_osc_en", 32'(osc_en), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_result", 32'(result), 0);
    chk("mid_rst_result_valid", 32'(result_valid), 0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_meas("post_reset", 16, 2, 4, 0, 4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
